answer_arbiter: RTL and testbench

- Shares the single factor-judge datapath between the two players during the INPUT phase of a round.
- Grants one submission at a time, with round-robin order on simultaneous presses.
- Drives a request/done handshake to the judge and applies a per-player lockout after a wrong answer.
- Reports sticky correct flags and one-cycle wrong pulses that the game controller decodes into GOOD/OUCH/DRAW/WRONG.

---
 rtl/answer_arbiter_pkg.sv | 19 +
 rtl/answer_arbiter_lock_timer.sv | 38 +++
 rtl/answer_arbiter.sv | 131 +++++++++++++
 tb/tb_answer_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/answer_arbiter_pkg.sv
// Shared types and sizing for the answer arbiter slice.
package answer_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_J = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    // Counter widths sized for the largest legal LOCK_TICKS / JUDGE_TMO.
    localparam int unsigned LOCK_TICKS_MAX = 15;
    localparam int unsigned JUDGE_TMO_MAX  = 255;
    localparam int unsigned LOCK_W         = $clog2(LOCK_TICKS_MAX + 1);
    localparam int unsigned TMO_W          = $clog2(JUDGE_TMO_MAX + 1);

endpackage

// File: rtl/answer_arbiter_lock_timer.sv
// Per-player lockout counter: loaded after a wrong answer, counts down on TICK.
module lock_timer
    import answer_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_TICKS = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic load,
    input  logic tick,
    output logic lock
);

    logic [LOCK_W-1:0] cnt_q;
    logic [LOCK_W-1:0] cnt_d;

    // Clear wins over load; a TICK coinciding with load is not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = LOCK_W'(LOCK_TICKS);
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign lock = (cnt_q != '0);

endmodule

// File: rtl/answer_arbiter.sv
// Grants the shared factor judge to one player at a time and tracks verdicts.
module answer_arbiter
    import answer_arbiter_pkg::*;
#(
    parameter int unsigned LOCK_TICKS = 3,
    parameter int unsigned JUDGE_TMO  = 15
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    input  logic       TICK,
    input  logic [1:0] REQ,
    output logic [1:0] GNT,
    output logic       JREQ,
    output logic       JPLAYER,
    input  logic       JDONE,
    input  logic       JCORRECT,
    output logic [1:0] JUDG_OUT,
    output logic [1:0] WRONG_PULSE,
    output logic [1:0] LOCK,
    output logic       BUSY
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(JUDGE_TMO - 1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic             player_q, player_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       judg_q, judg_d;
    logic [1:0]       wrong_q, wrong_d;
    logic [1:0]       lock_load;
    logic [1:0]       lock;
    logic [1:0]       eligible;
    logic             pick;

    lock_timer #(.LOCK_TICKS(LOCK_TICKS)) u_lock_p1 (
        .CLK (CLK),
        .RST (RST),
        .clr (~ENABLE),
        .load(lock_load[P1]),
        .tick(TICK),
        .lock(lock[P1])
    );

    lock_timer #(.LOCK_TICKS(LOCK_TICKS)) u_lock_p2 (
        .CLK (CLK),
        .RST (RST),
        .clr (~ENABLE),
        .load(lock_load[P2]),
        .tick(TICK),
        .lock(lock[P2])
    );

    // Next-state, grant selection, verdict handling; ENABLE low overrides all.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        player_d  = player_q;
        tmo_d     = tmo_q;
        gnt_d     = '0;
        wrong_d   = '0;
        judg_d    = judg_q;
        lock_load = '0;
        eligible  = REQ & ~lock;
        pick      = P1;
        if (!ENABLE) begin
            state_d = IDLE;
            judg_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        if (eligible == 2'b11) pick = ~last_q;
                        else                   pick = eligible[P2];
                        gnt_d[pick] = 1'b1;
                        player_d    = pick;
                        last_d      = pick;
                        tmo_d       = '0;
                        state_d     = WAIT_J;
                    end
                end
                WAIT_J: begin
                    if (JDONE && JCORRECT) begin
                        judg_d[player_q] = 1'b1;
                        state_d          = HOLD;
                    end else if (JDONE || (tmo_q == TMO_LAST)) begin
                        wrong_d[player_q]   = 1'b1;
                        lock_load[player_q] = 1'b1;
                        state_d             = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                HOLD:    state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            last_q   <= P2;
            player_q <= P1;
            tmo_q    <= '0;
            gnt_q    <= '0;
            judg_q   <= '0;
            wrong_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            player_q <= player_d;
            tmo_q    <= tmo_d;
            gnt_q    <= gnt_d;
            judg_q   <= judg_d;
            wrong_q  <= wrong_d;
        end
    end

    assign GNT         = gnt_q;
    assign JREQ        = (state_q == WAIT_J);
    assign JPLAYER     = player_q;
    assign JUDG_OUT    = judg_q;
    assign WRONG_PULSE = wrong_q;
    assign LOCK        = lock;
    assign BUSY        = (state_q != IDLE);

endmodule

// File: tb/tb_answer_arbiter.sv
// Scoreboard bench for answer_arbiter: expectations queued at stimulus, compared after the edge.
module tb_answer_arbiter;

    logic       CLK = 1'b0;
    logic       RST, ENABLE, TICK, JDONE, JCORRECT;
    logic [1:0] REQ;
    logic [1:0] GNT, JUDG_OUT, WRONG_PULSE, LOCK;
    logic       JREQ, JPLAYER, BUSY;

    typedef struct {
        string       name;
        logic [10:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 CLK = ~CLK;

    answer_arbiter #(.LOCK_TICKS(3), .JUDGE_TMO(15)) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TICK(TICK), .REQ(REQ),
        .GNT(GNT), .JREQ(JREQ), .JPLAYER(JPLAYER), .JDONE(JDONE),
        .JCORRECT(JCORRECT), .JUDG_OUT(JUDG_OUT), .WRONG_PULSE(WRONG_PULSE),
        .LOCK(LOCK), .BUSY(BUSY)
    );

    // JPLAYER only meaningful while JREQ is high.
    function automatic logic [10:0] obs();
        return {GNT, JREQ, JPLAYER & JREQ, JUDG_OUT, WRONG_PULSE, LOCK, BUSY};
    endfunction

    function automatic logic [10:0] mk(input logic [1:0] g, input logic jr, input logic jp,
                                       input logic [1:0] jo, input logic [1:0] w,
                                       input logic [1:0] l, input logic b);
        return {g, jr, jp, jo, w, l, b};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        exp_t ex;
        RST = 1'b1; ENABLE = 1'b0; REQ = 2'b00; TICK = 1'b0; JDONE = 1'b0; JCORRECT = 1'b0;
        exp_q.push_back('{"reset_state", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step(); step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        RST = 1'b0;
    endtask

    task automatic test_tie_rr();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b11;
        exp_q.push_back('{"tie_p1_first", mk(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b0;
        exp_q.push_back('{"p1_wrong", mk(2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 0)});
        step();
        JDONE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        for (int k = 0; k < 3; k++) begin
            TICK = 1'b1;
            exp_q.push_back('{"p1_lock_tick", mk(2'b00, 0, 0, 2'b00, 2'b00, (k < 2) ? 2'b01 : 2'b00, 0)});
            step();
            TICK = 1'b0;
            ex = exp_q.pop_front(); n_assert++;
            if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
            step();
        end
        REQ = 2'b11;
        exp_q.push_back('{"tie_rr_p2", mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b1;
        exp_q.push_back('{"p2_correct", mk(2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1)});
        step();
        JDONE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        ENABLE = 1'b0;
        exp_q.push_back('{"tie_clear", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
    endtask

    task automatic test_correct();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b01;
        exp_q.push_back('{"single_p1_grant", mk(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{"jreq_held", mk(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
            step();
            ex = exp_q.pop_front(); n_assert++;
            if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        end
        JDONE = 1'b1; JCORRECT = 1'b1;
        exp_q.push_back('{"p1_correct_hold", mk(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1)});
        step();
        JDONE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b10;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{"hold_ignores_req", mk(2'b00, 0, 0, 2'b01, 2'b00, 2'b00, 1)});
            step();
            ex = exp_q.pop_front(); n_assert++;
            if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        end
        ENABLE = 1'b0; REQ = 2'b00;
        exp_q.push_back('{"hold_clear", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
    endtask

    task automatic test_wrong_lock();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b10;
        exp_q.push_back('{"p2_grant", mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        JDONE = 1'b1; JCORRECT = 1'b0; TICK = 1'b1;
        exp_q.push_back('{"p2_wrong", mk(2'b00, 0, 0, 2'b00, 2'b10, 2'b10, 0)});
        step();
        JDONE = 1'b0; TICK = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        exp_q.push_back('{"p2_masked", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b10, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        for (int k = 0; k < 3; k++) begin
            TICK = 1'b1;
            exp_q.push_back('{"p2_lock_tick", mk(2'b00, 0, 0, 2'b00, 2'b00, (k < 2) ? 2'b10 : 2'b00, 0)});
            step();
            TICK = 1'b0;
            ex = exp_q.pop_front(); n_assert++;
            if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
            if (k < 2) step();
        end
        exp_q.push_back('{"p2_grant_after_lock", mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b1;
        exp_q.push_back('{"p2_correct", mk(2'b00, 0, 0, 2'b10, 2'b00, 2'b00, 1)});
        step();
        JDONE = 1'b0; ENABLE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        step();
    endtask

    task automatic test_timeout();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b01;
        exp_q.push_back('{"tmo_grant", mk(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00;
        for (int k = 0; k < 14; k++) begin
            exp_q.push_back('{"tmo_waiting", mk(2'b00, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
            step();
            ex = exp_q.pop_front(); n_assert++;
            if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        end
        exp_q.push_back('{"tmo_forced_wrong", mk(2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        ENABLE = 1'b0;
        exp_q.push_back('{"enable_clears_lock", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
    endtask

    task automatic test_enable_drop();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b1;
        exp_q.push_back('{"jdone_in_idle_ignored", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        JDONE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b10;
        exp_q.push_back('{"drop_grant", mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b1; ENABLE = 1'b0;
        exp_q.push_back('{"enable_drop_discards", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        JDONE = 1'b0; ENABLE = 1'b1;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        exp_q.push_back('{"idle_after_drop", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
    endtask

    task automatic test_rst_mid();
        exp_t ex;
        ENABLE = 1'b1; REQ = 2'b01;
        exp_q.push_back('{"rst_p1_grant", mk(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
        step();
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        REQ = 2'b00; JDONE = 1'b1; JCORRECT = 1'b0;
        exp_q.push_back('{"rst_p1_wrong", mk(2'b00, 0, 0, 2'b00, 2'b01, 2'b01, 0)});
        step();
        JDONE = 1'b0; REQ = 2'b10;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        exp_q.push_back('{"rst_p2_wait_locked_p1", mk(2'b10, 1, 1, 2'b00, 2'b00, 2'b01, 1)});
        step();
        REQ = 2'b00; RST = 1'b1;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        exp_q.push_back('{"reset_mid_wait", mk(2'b00, 0, 0, 2'b00, 2'b00, 2'b00, 0)});
        step();
        RST = 1'b0; REQ = 2'b11;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        exp_q.push_back('{"tie_after_mid_reset", mk(2'b01, 1, 0, 2'b00, 2'b00, 2'b00, 1)});
        step();
        REQ = 2'b00; ENABLE = 1'b0;
        ex = exp_q.pop_front(); n_assert++;
        if (obs() !== ex.v) begin n_fail++; $display("FAIL %s: got %b expected %b", ex.name, obs(), ex.v); end
        step();
    endtask

    initial begin
        test_reset();
        test_tie_rr();
        test_correct();
        test_wrong_lock();
        test_timeout();
        test_enable_drop();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
